// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch FSM states
// and the canonical NOP/HALT instruction words.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam logic [3:0] OP_ALU   = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [15:0] INSTR_NOP  = 16'h0000;
  localparam logic [15:0] INSTR_HALT = {OP_HALT, 12'h000};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/addr from the fetch unit, valid/rdata back
// from memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               valid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input valid, rdata);
  modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with direct load, wrapping increment and a pending-branch
// latch that redirects the next increment.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              pend_clr,
  output logic [ADDR_W-1:0] pc
);

  logic              pend_v;
  logic [ADDR_W-1:0] pend_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      pend_v <= 1'b0;
      pend_a <= '0;
    end else begin
      if (load)
        pc <= load_addr;
      else if (advance)
        pc <= pend_v ? pend_a : pc + ADDR_W'(1);

      // A newer redirect always overwrites an older one
      if (pend_set) begin
        pend_v <= 1'b1;
        pend_a <= pend_addr;
      end else if (pend_clr) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory handshake, IR and decoded fields.
// Optional watchdog on outstanding reads enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable,
  input  logic              halt,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  fetch_unit_if.master      imem,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        imm,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e       state, state_n;
  logic [INSTR_W-1:0] ir, ir_next;
  logic               ir_load, req_q;
  logic               pc_load, pc_advance, pend_set, pend_clr;
  logic               timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  assign timeout = (state == ST_WAIT) && !imem.valid && !halt
                   && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (state == ST_WAIT) ? tcnt + TW'(1) : '0;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    ir_load    = 1'b0;
    ir_next    = imem.rdata;
    pc_load    = 1'b0;
    pc_advance = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (halt) begin
          state_n = ST_HALTED;
        end else begin
          pc_load = branch_en;
          if (pc_enable)
            state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (halt) begin
          state_n  = ST_HALTED;
          pend_clr = 1'b1;
        end else if (imem.valid) begin
          // A redirect arriving with the data is the newest, so it beats any latched one
          ir_load    = 1'b1;
          state_n    = ST_IDLE;
          pend_clr   = 1'b1;
          pc_load    = branch_en;
          pc_advance = !branch_en;
        end else if (timeout) begin
          ir_load  = 1'b1;
          ir_next  = INSTR_W'(INSTR_HALT);
          state_n  = ST_IDLE;
          pend_clr = 1'b1;
        end else begin
          pend_set = branch_en;
        end
      end
      default: state_n = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state       <= state_n;
      instr_valid <= ir_load;
      req_q       <= (state_n == ST_WAIT);
      if (ir_load)
        ir <= ir_next;
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .load_addr (branch_target),
    .advance   (pc_advance),
    .pend_set  (pend_set),
    .pend_addr (branch_target),
    .pend_clr  (pend_clr),
    .pc        (pc)
  );

  assign imem.req   = req_q;
  assign imem.addr  = pc;
  assign fetch_busy = req_q;
  assign halted     = (state == ST_HALTED);
  assign opcode     = ir[OPC_LSB +: 4];
  assign rd         = ir[RD_LSB +: 2];
  assign rs         = ir[RS_LSB +: 2];
  assign imm        = ir[IMM_LSB +: 8];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_fetch_unit;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset, pc_enable, halt, branch_en;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] pc;
  logic [3:0]    opcode;
  logic [1:0]    rd, rs;
  logic [7:0]    imm;
  logic          instr_valid, fetch_busy, halted, fetch_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(16)) imem ();

  fetch_unit #(
    .ADDR_W      (AW),
    .INSTR_W     (16),
    .RESET_PC    (8'h00),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_enable     (pc_enable),
    .halt          (halt),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .imem          (imem.master),
    .pc            (pc),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .imm           (imm),
    .instr_valid   (instr_valid),
    .fetch_busy    (fetch_busy),
    .halted        (halted),
    .fetch_err     (fetch_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a read is either outstanding or not, redirects queue up
  // while one is outstanding and the newest one wins on completion.
  int          m_pc;
  logic [15:0] m_ir;
  bit          m_out, m_halted, m_iv;
  int          pend_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_ir = 16'h0000; m_out = 0; m_halted = 0; m_iv = 0;
      pend_q.delete();
    end else if (m_halted) begin
      m_iv = 0;
    end else if (halt) begin
      m_halted = 1; m_out = 0; m_iv = 0;
      pend_q.delete();
    end else if (!m_out) begin
      m_iv = 0;
      if (branch_en) m_pc = int'(branch_target);
      if (pc_enable) m_out = 1;
    end else begin
      if (branch_en) pend_q.push_back(int'(branch_target));
      if (imem.valid) begin
        m_ir  = imem.rdata;
        m_iv  = 1;
        m_pc  = (pend_q.size() > 0) ? pend_q[$] : (m_pc + 1) % (1 << AW);
        pend_q.delete();
        m_out = 0;
      end else begin
        m_iv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",          pc,          m_pc);
      chk("imem_addr",   imem.addr,   m_pc);
      chk("imem_req",    imem.req,    m_out);
      chk("fetch_busy",  fetch_busy,  m_out);
      chk("halted",      halted,      m_halted);
      chk("instr_valid", instr_valid, m_iv);
      chk("opcode",      opcode,      m_ir[15:12]);
      chk("rd",          rd,          m_ir[11:10]);
      chk("rs",          rs,          m_ir[9:8]);
      chk("imm",         imm,         m_ir[7:0]);
      chk("fetch_err",   fetch_err,   0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; pc_enable = 0; halt = 0; branch_en = 0; branch_target = '0;
    imem.valid = 0; imem.rdata = '0;
    step();
    chk_en = 1;
    step();
    reset = 0;
    chk("rst_pc", pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_req", imem.req, 0);

    // Basic fetch of 16'h3A55 from address 0
    pc_enable = 1; step(); pc_enable = 0;
    chk("f1_req", imem.req, 1);
    chk("f1_addr", imem.addr, 0);
    step();
    chk("f1_req_hold", imem.req, 1);
    imem.valid = 1; imem.rdata = 16'h3A55; step(); imem.valid = 0;
    chk("f1_opcode", opcode, 4'h3);
    chk("f1_rd", rd, 2);
    chk("f1_rs", rs, 2);
    chk("f1_imm", imm, 8'h55);
    chk("f1_iv", instr_valid, 1);
    chk("f1_pc", pc, 1);
    chk("f1_req_drop", imem.req, 0);
    step();
    chk("f1_iv_pulse", instr_valid, 0);

    // Wrap from 8'hFF
    branch_en = 1; branch_target = 8'hFF; step(); branch_en = 0;
    chk("wr_pc_ff", pc, 8'hFF);
    pc_enable = 1; step(); pc_enable = 0;
    chk("wr_addr0", imem.addr, 8'hFF);
    step();
    chk("wr_addr1", imem.addr, 8'hFF);
    imem.valid = 1; imem.rdata = 16'h8000; step(); imem.valid = 0;
    chk("wr_pc", pc, 8'h00);
    chk("wr_opcode", opcode, 4'h8);

    // Branch latched mid-read, applied on completion
    pc_enable = 1; step(); pc_enable = 0;
    step();
    branch_en = 1; branch_target = 8'h40; step(); branch_en = 0;
    chk("br_addr_hold", imem.addr, 8'h00);
    step(); step();
    imem.valid = 1; imem.rdata = 16'h4123; step(); imem.valid = 0;
    chk("br_pc", pc, 8'h40);
    chk("br_opcode", opcode, 4'h4);
    chk("br_imm", imm, 8'h23);
    pc_enable = 1; step(); pc_enable = 0;
    chk("br_next_addr", imem.addr, 8'h40);
    imem.valid = 1; imem.rdata = 16'h0000; step(); imem.valid = 0;
    chk("br_next_pc", pc, 8'h41);

    // Reset during an outstanding read, then a stray valid
    pc_enable = 1; step(); pc_enable = 0;
    reset = 1; step(); reset = 0;
    chk("rw_pc", pc, 0);
    chk("rw_req", imem.req, 0);
    imem.valid = 1; imem.rdata = 16'hFFFF; step(); imem.valid = 0;
    chk("rw_iv", instr_valid, 0);
    chk("rw_opcode", opcode, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      halt          = ($urandom_range(0, 199) == 0);
      pc_enable     = $urandom_range(0, 1);
      branch_en     = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 8'hFF : AW'($urandom);
      imem.rdata    = 16'($urandom);
      imem.valid    = imem.req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step();
    end
    reset = 1; halt = 0; pc_enable = 0; branch_en = 0; imem.valid = 0;
    step(); reset = 0;

    // Halt mid-read discards the returning data
    pc_enable = 1; step(); pc_enable = 0;
    step();
    halt = 1; step(); halt = 0;
    imem.valid = 1; imem.rdata = 16'h1111; step(); imem.valid = 0;
    chk("h_iv", instr_valid, 0);
    chk("h_req", imem.req, 0);
    chk("h_halted", halted, 1);
    chk("h_opcode", opcode, 0);
    pc_enable = 1; step(); step(); step(); pc_enable = 0;
    chk("h_req_stay", imem.req, 0);
    chk("h_pc", pc, 0);
    chk("h_halted_stay", halted, 1);

    // Without the watchdog a read stays outstanding indefinitely
    reset = 1; step(); reset = 0;
    pc_enable = 1; step(); pc_enable = 0;
    for (int i = 0; i < 110; i++) step();
    chk("nt_req", imem.req, 1);
    chk("nt_err", fetch_err, 0);
    chk("nt_pc", pc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
